// File: rtl/dma_sched_pkg.sv
// Shared types for the DMA job scheduler: FSM state encoding and the
// position of the enable bit inside the DMA enable register.
package dma_sched_pkg;

    // Scheduler FSM states: accept a job, program the DMA, run it, then
    // force one cycle of EN low so the DMA re-latches its configuration.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2,
        ST_CLEAR = 2'd3
    } state_e;

    // Bit of o_DMAEN that starts the DMA engine; all other bits stay 0.
    localparam int DMA_EN_BIT = 0;

endpackage

// File: rtl/dma_job_scheduler_if.sv
// Bundle of the requester job handshake and the DMA register/interrupt
// signals seen by the scheduler.
//
// Handshake: a requester raises req_valid[i] with req_src/dst/len slice i
// stable and keeps them stable until it sees req_ready[i]. req_ready[i] is a
// registered single-cycle pulse meaning "job i was captured at the previous
// clock edge"; the requester should drop req_valid[i] (or present a new job)
// after seeing it. done[i]/err[i] are single-cycle completion pulses.
interface dma_job_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*DATA_W-1:0] req_src;
    logic [NUM_REQ*DATA_W-1:0] req_dst;
    logic [NUM_REQ*DATA_W-1:0] req_len;
    logic [NUM_REQ-1:0]        done;
    logic [NUM_REQ-1:0]        err;
    logic [DATA_W-1:0]         o_DMAEN;
    logic [DATA_W-1:0]         o_DMASRC;
    logic [DATA_W-1:0]         o_DMADST;
    logic [DATA_W-1:0]         o_DMALEN;
    logic                      i_DMA_INTR;

    // Requesters and the DMA engine side.
    modport master (
        output req_valid, req_src, req_dst, req_len, i_DMA_INTR,
        input  req_ready, done, err, o_DMAEN, o_DMASRC, o_DMADST, o_DMALEN
    );

    // The scheduler.
    modport slave (
        input  req_valid, req_src, req_dst, req_len, i_DMA_INTR,
        output req_ready, done, err, o_DMAEN, o_DMASRC, o_DMADST, o_DMALEN
    );
endinterface

// File: rtl/dma_job_scheduler_rr_arbiter.sv
// Combinational round-robin picker: the first requesting index at or after
// ptr, wrapping past N-1 back to 0.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] idx,
    output logic                 any
);
    localparam int IDX_W = $clog2(N);

    // Scan N positions starting at ptr; the first hit wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!any && req[(int'(ptr) + i) % N]) begin
                any                          = 1'b1;
                grant[(int'(ptr) + i) % N]   = 1'b1;
                idx                          = IDX_W'((int'(ptr) + i) % N);
            end
        end
    end
endmodule

// File: rtl/dma_job_scheduler.sv
// Shares one DMA engine between NUM_REQ requesters: accepts one copy job at
// a time round-robin, programs the DMA registers, waits for the DMA
// interrupt (or a watchdog timeout) and reports done/err to the owner.
module dma_job_scheduler
    import dma_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int TMO_W   = 16
) (
    input  logic                       ACLK,
    input  logic                       ARESETn,
    dma_job_scheduler_if.slave         bus,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output state_e                     dbg_state
);
    localparam int ID_W = $clog2(NUM_REQ);

    // Captured job; held unchanged from acceptance until the next acceptance.
    typedef struct packed {
        logic [DATA_W-1:0] src;
        logic [DATA_W-1:0] dst;
        logic [DATA_W-1:0] len;
        logic [ID_W-1:0]   id;
    } job_t;

    function automatic logic [NUM_REQ-1:0] id_onehot(input logic [ID_W-1:0] id);
        id_onehot     = '0;
        id_onehot[id] = 1'b1;
    endfunction

    state_e             state_q, state_d;
    job_t               job_q, job_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [TMO_W-1:0]   wdog_q, wdog_d, wdog_inc;
    logic               zlen_q, zlen_d;

    logic [NUM_REQ-1:0] ready_q, ready_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic [NUM_REQ-1:0] err_q, err_d;
    logic               en_q, en_d;
    logic [DATA_W-1:0]  src_q, src_d;
    logic [DATA_W-1:0]  dst_q, dst_d;
    logic [DATA_W-1:0]  len_q, len_d;
    logic               busy_q, busy_d;
    logic [ID_W-1:0]    gid_q, gid_d;
    logic               drive_regs;

    logic [NUM_REQ-1:0] arb_req;
    logic [NUM_REQ-1:0] arb_grant;
    logic [ID_W-1:0]    arb_idx;
    logic               arb_any;

    // A requester whose ready pulse is showing right now may still have
    // valid high for this edge; masking it prevents accepting the same job
    // twice (matters for zero-length jobs, where we stay in IDLE).
    assign arb_req  = bus.req_valid & ~ready_q;
    assign wdog_inc = wdog_q + 1'b1;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req   (arb_req),
        .ptr   (rr_ptr_q),
        .grant (arb_grant),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    // State register.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Next state, job capture, watchdog and next values of every output.
    always_comb begin
        state_d  = state_q;
        job_d    = job_q;
        rr_ptr_d = rr_ptr_q;
        wdog_d   = '0;
        zlen_d   = 1'b0;
        ready_d  = '0;
        done_d   = '0;
        err_d    = '0;

        // Zero-length job accepted last edge: report it now, DMA untouched.
        if (zlen_q) done_d = id_onehot(job_q.id);

        unique case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    ready_d   = arb_grant;
                    job_d.src = bus.req_src[arb_idx*DATA_W +: DATA_W];
                    job_d.dst = bus.req_dst[arb_idx*DATA_W +: DATA_W];
                    job_d.len = bus.req_len[arb_idx*DATA_W +: DATA_W];
                    job_d.id  = arb_idx;
                    rr_ptr_d  = (arb_idx == ID_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
                    if (job_d.len == '0) zlen_d  = 1'b1;
                    else                 state_d = ST_LOAD;
                end
            end
            ST_LOAD: state_d = ST_RUN;
            ST_RUN: begin
                // wdog counts RUN cycles; it times out on the cycle it reaches
                // all-ones. The interrupt takes priority on that same cycle.
                wdog_d = wdog_inc;
                if (bus.i_DMA_INTR) begin
                    done_d  = id_onehot(job_q.id);
                    state_d = ST_CLEAR;
                end else if (wdog_inc == '1) begin
                    err_d   = id_onehot(job_q.id);
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        // Outputs are registered images of the state being entered.
        drive_regs = (state_d == ST_LOAD) || (state_d == ST_RUN);
        en_d       = (state_d == ST_RUN);
        src_d      = drive_regs ? job_d.src : '0;
        dst_d      = drive_regs ? job_d.dst : '0;
        len_d      = drive_regs ? job_d.len : '0;
        busy_d     = (state_d != ST_IDLE);
        gid_d      = busy_d ? job_d.id : '0;
    end

    // Job, pointer, watchdog and registered outputs.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            job_q    <= '0;
            rr_ptr_q <= '0;
            wdog_q   <= '0;
            zlen_q   <= 1'b0;
            ready_q  <= '0;
            done_q   <= '0;
            err_q    <= '0;
            en_q     <= 1'b0;
            src_q    <= '0;
            dst_q    <= '0;
            len_q    <= '0;
            busy_q   <= 1'b0;
            gid_q    <= '0;
        end else begin
            job_q    <= job_d;
            rr_ptr_q <= rr_ptr_d;
            wdog_q   <= wdog_d;
            zlen_q   <= zlen_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
            err_q    <= err_d;
            en_q     <= en_d;
            src_q    <= src_d;
            dst_q    <= dst_d;
            len_q    <= len_d;
            busy_q   <= busy_d;
            gid_q    <= gid_d;
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.o_DMAEN   = DATA_W'(en_q) << DMA_EN_BIT;
    assign bus.o_DMASRC  = src_q;
    assign bus.o_DMADST  = dst_q;
    assign bus.o_DMALEN  = len_q;
    assign busy          = busy_q;
    assign grant_id      = gid_q;
    assign dbg_state     = state_q;
endmodule

// File: tb/tb_dma_job_scheduler.sv
// Directed bench for dma_job_scheduler: one instance with the default
// watchdog, one with a 4-bit watchdog for the timeout cases.
module tb_dma_job_scheduler;
    import dma_sched_pkg::*;

    logic   ACLK = 1'b0;
    logic   ARESETn = 1'b0;
    logic   busy_a, busy_b;
    logic [1:0] gid_a, gid_b;
    state_e st_a, st_b;
    int     checks = 0;
    int     errors = 0;
    logic   hold_ok;
    int     exp_id;
    int     waited;

    dma_job_scheduler_if #(.NUM_REQ(4), .DATA_W(32)) bus_a ();
    dma_job_scheduler_if #(.NUM_REQ(4), .DATA_W(32)) bus_b ();

    dma_job_scheduler #(.NUM_REQ(4), .DATA_W(32), .TMO_W(16)) dut_a (
        .ACLK(ACLK), .ARESETn(ARESETn), .bus(bus_a),
        .busy(busy_a), .grant_id(gid_a), .dbg_state(st_a)
    );

    dma_job_scheduler #(.NUM_REQ(4), .DATA_W(32), .TMO_W(4)) dut_b (
        .ACLK(ACLK), .ARESETn(ARESETn), .bus(bus_b),
        .busy(busy_b), .grant_id(gid_b), .dbg_state(st_b)
    );

    // Clock
    always #5 ACLK = ~ACLK;

    // Advance one cycle; sample and drive 1 time unit after the edge.
    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        ARESETn = 1'b0;
        bus_a.req_valid = '0; bus_a.i_DMA_INTR = 1'b0;
        bus_b.req_valid = '0; bus_b.i_DMA_INTR = 1'b0;
        repeat (2) tick();
        ARESETn = 1'b1;
    endtask

    task automatic set_job_a(input int p, input logic [31:0] s, input logic [31:0] d, input logic [31:0] l);
        bus_a.req_src[p*32 +: 32] = s;
        bus_a.req_dst[p*32 +: 32] = d;
        bus_a.req_len[p*32 +: 32] = l;
    endtask

    task automatic set_job_b(input int p, input logic [31:0] s, input logic [31:0] d, input logic [31:0] l);
        bus_b.req_src[p*32 +: 32] = s;
        bus_b.req_dst[p*32 +: 32] = d;
        bus_b.req_len[p*32 +: 32] = l;
    endtask

    initial begin
        bus_a.req_src = '0; bus_a.req_dst = '0; bus_a.req_len = '0;
        bus_b.req_src = '0; bus_b.req_dst = '0; bus_b.req_len = '0;
        do_reset();

        // Reset state
        check("rst_busy",  busy_a, 0);
        check("rst_gid",   gid_a, 0);
        check("rst_state", st_a, ST_IDLE);
        check("rst_ready", bus_a.req_ready, 0);
        check("rst_done",  bus_a.done, 0);
        check("rst_err",   bus_a.err, 0);
        check("rst_en",    bus_a.o_DMAEN, 0);
        check("rst_src",   bus_a.o_DMASRC, 0);
        check("rst_dst",   bus_a.o_DMADST, 0);
        check("rst_len",   bus_a.o_DMALEN, 0);
        check("rst_b_en",  bus_b.o_DMAEN, 0);

        // 1: single job on requester 0
        set_job_a(0, 32'h1000, 32'h2000, 32'd20);
        bus_a.req_valid = 4'b0001;
        tick();
        check("t1_ready",  bus_a.req_ready, 4'b0001);
        check("t1_load",   st_a, ST_LOAD);
        check("t1_en_ld",  bus_a.o_DMAEN, 0);
        check("t1_src_ld", bus_a.o_DMASRC, 32'h1000);
        check("t1_busy",   busy_a, 1);
        bus_a.req_valid = 4'b0000;
        tick();
        check("t1_en_lat", bus_a.o_DMAEN, 1);
        check("t1_run",    st_a, ST_RUN);
        check("t1_dst",    bus_a.o_DMADST, 32'h2000);
        check("t1_len",    bus_a.o_DMALEN, 32'd20);
        check("t1_rdy0",   bus_a.req_ready, 0);
        hold_ok = 1'b1;
        repeat (39) begin
            tick();
            if (bus_a.o_DMAEN !== 32'd1 || bus_a.o_DMASRC !== 32'h1000 ||
                bus_a.o_DMADST !== 32'h2000 || bus_a.o_DMALEN !== 32'd20 ||
                bus_a.done !== 4'b0) hold_ok = 1'b0;
        end
        check("t1_hold", hold_ok, 1);
        bus_a.i_DMA_INTR = 1'b1;
        tick();
        bus_a.i_DMA_INTR = 1'b0;
        check("t1_done",   bus_a.done, 4'b0001);
        check("t1_clr_en", bus_a.o_DMAEN, 0);
        check("t1_clr_src", bus_a.o_DMASRC, 0);
        check("t1_clear",  st_a, ST_CLEAR);
        check("t1_busy_c", busy_a, 1);
        tick();
        check("t1_done1",  bus_a.done, 0);
        check("t1_idle",   busy_a, 0);
        check("t1_gid0",   gid_a, 0);

        // 2: all four requesting, eight jobs in round-robin order
        do_reset();
        for (int i = 0; i < 4; i++) set_job_a(i, 32'h100 * (i + 1), 32'h8000 + i, i + 1);
        bus_a.req_valid = 4'b1111;
        for (int j = 0; j < 8; j++) begin
            exp_id = j % 4;
            waited = 0;
            tick();
            while (bus_a.req_ready == 4'b0 && waited < 10) begin
                tick();
                waited++;
            end
            check($sformatf("t2_ready_%0d", j), bus_a.req_ready, 64'd1 << exp_id);
            check($sformatf("t2_gid_%0d", j), gid_a, exp_id);
            tick();
            check($sformatf("t2_en_%0d", j), bus_a.o_DMAEN, 1);
            check($sformatf("t2_src_%0d", j), bus_a.o_DMASRC, 32'h100 * (exp_id + 1));
            check($sformatf("t2_rdy1_%0d", j), bus_a.req_ready, 0);
            bus_a.i_DMA_INTR = 1'b1;
            tick();
            bus_a.i_DMA_INTR = 1'b0;
            check($sformatf("t2_done_%0d", j), bus_a.done, 64'd1 << exp_id);
            tick();
        end
        bus_a.req_valid = 4'b0000;

        // 3: zero-length job on requester 2
        set_job_a(2, 32'h3000, 32'h4000, 32'd0);
        bus_a.req_valid = 4'b0100;
        tick();
        check("t3_ready",  bus_a.req_ready, 4'b0100);
        check("t3_done0",  bus_a.done, 0);
        check("t3_state",  st_a, ST_IDLE);
        check("t3_busy",   busy_a, 0);
        check("t3_en0",    bus_a.o_DMAEN, 0);
        bus_a.req_valid = 4'b0000;
        tick();
        check("t3_done",   bus_a.done, 4'b0100);
        check("t3_rdy1",   bus_a.req_ready, 0);
        check("t3_en1",    bus_a.o_DMAEN, 0);
        tick();
        check("t3_done2",  bus_a.done, 0);
        check("t3_en2",    bus_a.o_DMAEN, 0);

        // 4: watchdog timeout with TMO_W=4, then a normal job
        set_job_b(1, 32'h10, 32'h20, 32'd5);
        bus_b.req_valid = 4'b0010;
        tick();
        check("t4_ready",  bus_b.req_ready, 4'b0010);
        bus_b.req_valid = 4'b0000;
        tick();
        check("t4_en",     bus_b.o_DMAEN, 1);
        hold_ok = 1'b1;
        repeat (14) begin
            tick();
            if (bus_b.err !== 4'b0 || bus_b.o_DMAEN !== 32'd1) hold_ok = 1'b0;
        end
        check("t4_run15",  hold_ok, 1);
        tick();
        check("t4_err",    bus_b.err, 4'b0010);
        check("t4_done0",  bus_b.done, 0);
        check("t4_en_off", bus_b.o_DMAEN, 0);
        tick();
        check("t4_err1",   bus_b.err, 0);
        check("t4_idle",   busy_b, 0);
        set_job_b(3, 32'h30, 32'h40, 32'd3);
        bus_b.req_valid = 4'b1000;
        tick();
        check("t4_ready2", bus_b.req_ready, 4'b1000);
        bus_b.req_valid = 4'b0000;
        tick();
        check("t4_en2",    bus_b.o_DMAEN, 1);
        check("t4_src2",   bus_b.o_DMASRC, 32'h30);
        bus_b.i_DMA_INTR = 1'b1;
        tick();
        bus_b.i_DMA_INTR = 1'b0;
        check("t4_done2",  bus_b.done, 4'b1000);
        check("t4_err2",   bus_b.err, 0);
        tick();

        // 5: interrupt on the watchdog terminal cycle
        set_job_b(0, 32'h50, 32'h60, 32'd7);
        bus_b.req_valid = 4'b0001;
        tick();
        check("t5_ready",  bus_b.req_ready, 4'b0001);
        bus_b.req_valid = 4'b0000;
        tick();
        repeat (14) tick();
        check("t5_en15",   bus_b.o_DMAEN, 1);
        check("t5_err15",  bus_b.err, 0);
        bus_b.i_DMA_INTR = 1'b1;
        tick();
        bus_b.i_DMA_INTR = 1'b0;
        check("t5_done",   bus_b.done, 4'b0001);
        check("t5_err",    bus_b.err, 0);
        check("t5_clear",  st_b, ST_CLEAR);
        tick();
        check("t5_err1",   bus_b.err, 0);
        check("t5_done1",  bus_b.done, 0);

        // 6: reset during RUN, then pending requests granted from pointer 0
        set_job_a(1, 32'h5000, 32'h6000, 32'd9);
        bus_a.req_valid = 4'b0010;
        tick();
        check("t6_ready",  bus_a.req_ready, 4'b0010);
        bus_a.req_valid = 4'b0000;
        repeat (3) tick();
        check("t6_en",     bus_a.o_DMAEN, 1);
        set_job_a(3, 32'h7000, 32'h7100, 32'd4);
        bus_a.req_valid = 4'b1010;
        #2;
        ARESETn = 1'b0;
        #1;
        check("t6_rst_en",   bus_a.o_DMAEN, 0);
        check("t6_rst_busy", busy_a, 0);
        check("t6_rst_src",  bus_a.o_DMASRC, 0);
        check("t6_rst_st",   st_a, ST_IDLE);
        check("t6_rst_rdy",  bus_a.req_ready, 0);
        #1;
        ARESETn = 1'b1;
        tick();
        check("t6_ready2", bus_a.req_ready, 4'b0010);
        check("t6_done",   bus_a.done, 0);
        check("t6_err",    bus_a.err, 0);
        bus_a.req_valid = 4'b0000;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Safety net: the directed sequence is far shorter than this.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, checks=%0d", checks);
        $fatal(1, "timeout");
    end
endmodule
